// File: rtl/reorder_buffer_if.sv
// Handshake bundle between the rename/execute pipeline and the reorder buffer.
// The master drives allocation, completion and control; the slave is the buffer.
interface reorder_buffer_if #(
    parameter int NUM_ROB  = 16,
    parameter int NUM_REG  = 32,
    parameter int NUM_TAGS = 64
);
    localparam int NUM_ROB_LOG2  = $clog2(NUM_ROB);
    localparam int NUM_REG_LOG2  = $clog2(NUM_REG);
    localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);

    logic                     flush;
    logic                     alloc_valid;
    logic [NUM_REG_LOG2-1:0]  alloc_rd;
    logic [NUM_TAGS_LOG2-1:0] alloc_old_tag;
    logic                     alloc_ready;
    logic [NUM_ROB_LOG2-1:0]  alloc_idx;
    logic                     complete_valid;
    logic [NUM_ROB_LOG2-1:0]  complete_idx;
    logic                     retire_stall;
    logic                     commit_valid;
    logic                     retire_valid;
    logic [NUM_TAGS_LOG2-1:0] retire_tag;
    logic [NUM_REG_LOG2-1:0]  retire_rd;
    logic                     empty;

    modport master (
        output flush, alloc_valid, alloc_rd, alloc_old_tag,
               complete_valid, complete_idx, retire_stall,
        input  alloc_ready, alloc_idx, commit_valid, retire_valid,
               retire_tag, retire_rd, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_rd, alloc_old_tag,
               complete_valid, complete_idx, retire_stall,
        output alloc_ready, alloc_idx, commit_valid, retire_valid,
               retire_tag, retire_rd, empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement controller: entries allocate at the tail, complete out of
// order, and retire from the head one per cycle, freeing the displaced physical tag.
module reorder_buffer #(
    parameter int NUM_ROB       = 16,
    parameter int NUM_REG       = 32,
    parameter int NUM_TAGS      = 64,
    parameter int NUM_ROB_LOG2  = $clog2(NUM_ROB),
    parameter int NUM_REG_LOG2  = $clog2(NUM_REG),
    parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS)
) (
    input  logic              clk,
    input  logic              rst,
    reorder_buffer_if.slave   rob
);
    localparam logic [NUM_ROB_LOG2:0] FULL_CNT = (NUM_ROB_LOG2 + 1)'(NUM_ROB);

    logic [NUM_ROB-1:0]       r_valid;
    logic [NUM_ROB-1:0]       r_done;
    logic [NUM_REG_LOG2-1:0]  r_rd      [NUM_ROB];
    logic [NUM_TAGS_LOG2-1:0] r_old_tag [NUM_ROB];
    logic [NUM_ROB_LOG2-1:0]  r_head;
    logic [NUM_ROB_LOG2-1:0]  r_tail;
    logic [NUM_ROB_LOG2:0]    r_count;
    logic                     r_commit_valid;
    logic                     r_retire_valid;
    logic [NUM_TAGS_LOG2-1:0] r_retire_tag;
    logic [NUM_REG_LOG2-1:0]  r_retire_rd;

    logic w_alloc_ready;
    logic w_alloc_fire;
    logic w_complete_fire;
    logic w_retire_fire;

    // No full-bypass: a full buffer refuses allocation even while it retires.
    assign w_alloc_ready   = (r_count != FULL_CNT);
    assign w_alloc_fire    = rob.alloc_valid & w_alloc_ready;
    assign w_complete_fire = rob.complete_valid & r_valid[rob.complete_idx]
                           & ~(w_alloc_fire & (rob.complete_idx == r_tail));
    assign w_retire_fire   = r_valid[r_head] & r_done[r_head] & ~rob.retire_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_retire_valid <= 1'b0;
            r_retire_tag   <= '0;
            r_retire_rd    <= '0;
        end else if (rob.flush) begin
            r_valid        <= '0;
            r_done         <= '0;
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_retire_valid <= 1'b0;
        end else begin
            if (w_complete_fire) begin
                r_done[rob.complete_idx] <= 1'b1;
            end
            if (w_alloc_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            // Head clear comes last; it can never collide with the tail write
            // because allocation into a full buffer is refused.
            if (w_retire_fire) begin
                r_valid[r_head] <= 1'b0;
                r_done[r_head]  <= 1'b0;
                r_head          <= r_head + 1'b1;
                r_retire_tag    <= r_old_tag[r_head];
                r_retire_rd     <= r_rd[r_head];
            end
            r_commit_valid <= w_retire_fire;
            r_retire_valid <= w_retire_fire & (r_rd[r_head] != '0);
            case ({w_alloc_fire, w_retire_fire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage is only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_rd[r_tail]      <= rob.alloc_rd;
            r_old_tag[r_tail] <= rob.alloc_old_tag;
        end
    end

    assign rob.alloc_ready  = w_alloc_ready;
    assign rob.alloc_idx    = r_tail;
    assign rob.empty        = (r_count == '0);
    assign rob.commit_valid = r_commit_valid;
    assign rob.retire_valid = r_retire_valid;
    assign rob.retire_tag   = r_retire_tag;
    assign rob.retire_rd    = r_retire_rd;
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order retirement controller for the renamed instruction stream. Each renamed instruction enters a circular buffer at allocation. Execution completions are accepted out of order, and instructions retire strictly in program order at one per cycle. On retirement the block returns the displaced physical tag, the old RAT mapping of rd, to the rename stage's free pool through `retire_valid`/`retire_tag`.

## Interface
- `NUM_ROB`, 16: number of entries. Must be a power of two, at least 2.
- `NUM_REG`, 32: architectural registers.
- `NUM_TAGS`, 64: physical tags.
- `NUM_ROB_LOG2`, `$clog2(NUM_ROB)`: entry index width.
- `NUM_REG_LOG2`, `$clog2(NUM_REG)`: register index width.
- `NUM_TAGS_LOG2`, `$clog2(NUM_TAGS)`: tag width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous discard of all entries.
- `alloc_valid`  in  1  a renamed instruction is presented.
- `alloc_rd`  in  NUM_REG_LOG2  destination architectural register.
- `alloc_old_tag`  in  NUM_TAGS_LOG2  tag mapped to rd before rename; freed at retire.
- `alloc_ready`  out  1  buffer can accept an entry this cycle.
- `alloc_idx`  out  NUM_ROB_LOG2  entry index given to the presented instruction (the tail).
- `complete_valid`  in  1  an execution unit reports completion.
- `complete_idx`  in  NUM_ROB_LOG2  entry being completed.
- `retire_stall`  in  1  holds retirement.
- `commit_valid`  out  1  one entry retired (registered pulse).
- `retire_valid`  out  1  commit with rd != 0; frees `retire_tag`.
- `retire_tag`  out  NUM_TAGS_LOG2  old tag being freed.
- `retire_rd`  out  NUM_REG_LOG2  rd of the retired entry.
- `empty`  out  1  count == 0.

## Operation
- **Per-entry state:** `valid`, `done`, `rd`, `old_tag`. Head and tail pointers are NUM_ROB_LOG2 wide and wrap modulo NUM_ROB. `count` is NUM_ROB_LOG2+1 bits wide.
- **Allocation:** fires when `alloc_valid & alloc_ready`. Entry[tail] is written with `valid=1`, `done=0`, `rd`, `old_tag`. Then the tail increments and the count increments.
- **Ready and index:** `alloc_ready = (count != NUM_ROB)` and `alloc_idx = tail`, both combinational from registers. There is no full-bypass: a full buffer refuses allocation even in a cycle where it retires.
- **Completion:** sets entry[complete_idx].done if that entry is valid. Completion to an invalid entry is ignored. So is completion to the entry being allocated in the same cycle.
- **Retirement:** when `entry[head].valid & entry[head].done & ~retire_stall`, the entry is cleared, the head increments and the count decrements. The output registers load on the same edge:
  - `commit_valid <= 1`
  - `retire_rd <= rd`
  - `retire_tag <= old_tag`
  - `retire_valid <= (rd != 0)`
- **No retirement:** `commit_valid` and `retire_valid` load 0. `retire_tag` and `retire_rd` hold their values.
- **Simultaneous allocate and retire:** the count is unchanged and both pointers advance.
- **Flush:** clears every valid bit, the head, the tail and the count. It also forces `commit_valid` and `retire_valid` to 0 on the next edge. It overrides allocation, completion and retirement in the same cycle.
- **Priority:** `rst` takes priority over `flush`.

## Timing
- **Reset values:**
  - `alloc_ready=1`, `alloc_idx=0`, `empty=1`
  - `commit_valid=0`, `retire_valid=0`, `retire_tag=0`, `retire_rd=0`
  - all entries invalid
- **Reset mid-operation:** all in-flight entries are lost and no retire pulse is emitted.
- **Allocation latency:** an entry allocated at edge N is visible at edge N+1, and `empty` falls in cycle N+1.
- **Retirement latency:** completion at edge N sets `done`. Retirement evaluates in cycle N+1 and pops at edge N+1, so `retire_valid` is high during cycle N+2. Minimum alloc-to-retire time is 3 cycles.
- **Throughput:** at most one retirement per cycle.
- **Stall:** `retire_stall` high in cycle K blocks the pop at edge K. The next output cycle has no commit pulse.

## Test plan
1. **Reset:** assert `rst` 2 cycles. Require `alloc_ready=1`, `alloc_idx=0`, `empty=1`, `retire_valid=0`, `commit_valid=0`.
2. **Out-of-order completion:** allocate 3 entries (rd=5, old_tag=7), (rd=6, old_tag=9), (rd=8, old_tag=40). Complete idx 2, then 0, then 1, one per cycle. Require retire pulses in order with tags 7, 9, 40 on consecutive cycles, starting 2 cycles after the idx 0 completion.
3. **Full and wrap:** allocate 16 entries. Require `alloc_ready=0` and `alloc_idx=0`. Retire one entry, then allocate. Require the new entry at idx 0. Also check that retire plus `alloc_valid` in the full cycle does not allocate.
4. **rd == 0:** allocate rd=0 with old_tag=0, then complete it. Require `commit_valid=1`, `retire_valid=0` and no tag freed.
5. **Stall and flush:** with a done head, hold `retire_stall` 3 cycles. Require no commit, then a pulse 1 cycle after release. Then allocate 4 entries and flush. Require `empty=1` next cycle, and no retire pulse after a later completion to idx 1.
6. **Invalid completion:** `complete_valid` on an unallocated idx=9. Require no state change and no retire.
